// File: rtl/sync_fifo_pkg.sv
// Shared constants and the status bundle for sync_fifo_param and its bench monitors.
package sync_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic alm_full;
    logic alm_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Array contents are deliberately left out of reset so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Output register holds its value between accepted reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count and read-valid strobe.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow error flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ALM_FULL_TH  = DEPTH - 2,
  parameter int ALM_EMPTY_TH = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic              i_err_clr,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [CW-1:0]     o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  if (DATA_W < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      ALM_EMPTY_TH < 1 || ALM_EMPTY_TH >= ALM_FULL_TH || ALM_FULL_TH > DEPTH - 1) begin : g_param_err
    $error("sync_fifo_param: illegal DATA_W/DEPTH/threshold combination");
  end

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(ALM_FULL_TH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALM_EMPTY_TH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdvalid_q, rdvalid_d;
  logic          wr_acc, rd_acc;
  logic          err_ovf, err_udf;
  fifo_status_t  status;

  // Flags decode only from registered state, so no input reaches an output combinationally.
  always_comb begin
    status           = '0;
    status.full      = (count_q == DEPTH_C);
    status.empty     = (count_q == '0);
    status.alm_full  = (count_q >= AF_TH);
    status.alm_empty = (count_q <= AE_TH);
    status.overflow  = err_ovf;
    status.underflow = err_udf;
  end

  assign wr_acc = i_wren && !status.full;
  assign rd_acc = i_rden && !status.empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rdvalid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdvalid_q <= rdvalid_d;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new error event in the clearing cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_q && !i_err_clr;
    udf_d = udf_q && !i_err_clr;
    if (i_wren && status.full)  ovf_d = 1'b1;
    if (i_rden && status.empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign err_ovf = ovf_q;
  assign err_udf = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign err_ovf        = 1'b0;
  assign err_udf        = 1'b0;
`endif

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (i_wrdata),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (o_rddata)
  );

  assign o_rdvalid   = rdvalid_q;
  assign o_count     = count_q;
  assign o_full      = status.full;
  assign o_empty     = status.empty;
  assign o_alm_full  = status.alm_full;
  assign o_alm_empty = status.alm_empty;
  assign o_overflow  = status.overflow;
  assign o_underflow = status.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=8, thresholds 6/2).
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int CW = $clog2(DP) + 1;
`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_wren, i_rden, i_err_clr;
  logic [DW-1:0] i_wrdata;
  logic [DW-1:0] o_rddata;
  logic          o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty;
  logic [CW-1:0] o_count;
  logic          o_overflow, o_underflow;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W       (DW),
    .DEPTH        (DP),
    .ALM_FULL_TH  (6),
    .ALM_EMPTY_TH (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_wren      (i_wren),
    .i_wrdata    (i_wrdata),
    .i_rden      (i_rden),
    .i_err_clr   (i_err_clr),
    .o_rddata    (o_rddata),
    .o_rdvalid   (o_rdvalid),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
    .o_alm_empty (o_alm_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_empty"}, 32'(o_empty), 32'd1);
    chk({tag, "_alm_empty"}, 32'(o_alm_empty), 32'd1);
    chk({tag, "_full"}, 32'(o_full), 32'd0);
    chk({tag, "_alm_full"}, 32'(o_alm_full), 32'd0);
    chk({tag, "_count"}, 32'(o_count), 32'd0);
    chk({tag, "_rddata"}, 32'(o_rddata), 32'd0);
    chk({tag, "_rdvalid"}, 32'(o_rdvalid), 32'd0);
    chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
    chk({tag, "_udf"}, 32'(o_underflow), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; i_wren = 1'b0; i_rden = 1'b0; i_err_clr = 1'b0; i_wrdata = '0;
    repeat (3) step();
    rstn = 1'b1;
    step();
    chk_idle_reset("reset");
    $display("reset released, outputs idle");

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      i_wren = 1'b1; i_wrdata = DW'(i);
      step();
      chk($sformatf("fill%0d_count", i), 32'(o_count), 32'(i));
      chk($sformatf("fill%0d_alm_empty", i), 32'(o_alm_empty), 32'(i <= 2));
      chk($sformatf("fill%0d_alm_full", i), 32'(o_alm_full), 32'(i >= 6));
      chk($sformatf("fill%0d_full", i), 32'(o_full), 32'(i == 8));
      chk($sformatf("fill%0d_empty", i), 32'(o_empty), 32'd0);
      chk($sformatf("fill%0d_ovf", i), 32'(o_overflow), 32'd0);
      $display("write 0x%02h count=%0d", i_wrdata, o_count);
    end
    i_wrdata = 8'hFF;
    step();
    i_wren = 1'b0;
    chk("ovwr_count", 32'(o_count), 32'd8);
    chk("ovwr_full", 32'(o_full), 32'd1);
    chk("ovwr_ovf", 32'(o_overflow), 32'(ERR_EN));
    $display("write 0xff while full, count=%0d overflow=%0b", o_count, o_overflow);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      i_rden = 1'b1;
      step();
      chk($sformatf("drain%0d_data", i), 32'(o_rddata), 32'(i));
      chk($sformatf("drain%0d_valid", i), 32'(o_rdvalid), 32'd1);
      chk($sformatf("drain%0d_count", i), 32'(o_count), 32'(8 - i));
      $display("read 0x%02h count=%0d", o_rddata, o_count);
    end
    step();
    i_rden = 1'b0;
    chk("udrd_valid", 32'(o_rdvalid), 32'd0);
    chk("udrd_data", 32'(o_rddata), 32'h08);
    chk("udrd_empty", 32'(o_empty), 32'd1);
    chk("udrd_udf", 32'(o_underflow), 32'(ERR_EN));
    chk("udrd_ovf_held", 32'(o_overflow), 32'(ERR_EN));
    $display("read while empty, rddata=0x%02h underflow=%0b", o_rddata, o_underflow);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk("clr1_ovf", 32'(o_overflow), 32'd0);
    chk("clr1_udf", 32'(o_underflow), 32'd0);

    // Wrap: preload 4 words, then 20 cycles of concurrent write+read
    for (int i = 0; i < 4; i++) begin
      i_wren = 1'b1; i_wrdata = DW'(8'h10 + i);
      step();
    end
    chk("wrap_pre_count", 32'(o_count), 32'd4);
    i_rden = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_wrdata = DW'(8'h14 + k);
      step();
      chk($sformatf("wrap%0d_data", k), 32'(o_rddata), 32'(8'h10 + k));
      chk($sformatf("wrap%0d_count", k), 32'(o_count), 32'd4);
      chk($sformatf("wrap%0d_fe", k), 32'({o_full, o_empty, o_rdvalid}), 32'b001);
      $display("wrap w=0x%02h r=0x%02h count=%0d", i_wrdata, o_rddata, o_count);
    end
    i_wren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("wraptail%0d_data", k), 32'(o_rddata), 32'(8'h24 + k));
    end
    i_rden = 1'b0;
    chk("wraptail_empty", 32'(o_empty), 32'd1);

    // Boundary: full with write+read accepts only the read
    for (int i = 0; i < 8; i++) begin
      i_wren = 1'b1; i_wrdata = DW'(8'h30 + i);
      step();
    end
    chk("bfull_full", 32'(o_full), 32'd1);
    i_rden = 1'b1; i_wrdata = 8'hAA;
    step();
    i_wren = 1'b0;
    chk("bfull_count", 32'(o_count), 32'd7);
    chk("bfull_full_after", 32'(o_full), 32'd0);
    chk("bfull_data", 32'(o_rddata), 32'h30);
    chk("bfull_valid", 32'(o_rdvalid), 32'd1);
    chk("bfull_ovf", 32'(o_overflow), 32'(ERR_EN));
    $display("full wr+rd: read 0x%02h count=%0d", o_rddata, o_count);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("bdrain%0d_data", i), 32'(o_rddata), 32'(8'h30 + i));
    end
    i_rden = 1'b0;
    chk("bdrain_count", 32'(o_count), 32'd0);

    // Boundary: empty with write+read accepts only the write, no bypass
    i_wren = 1'b1; i_rden = 1'b1; i_wrdata = 8'h55;
    step();
    i_wren = 1'b0; i_rden = 1'b0;
    chk("bempty_count", 32'(o_count), 32'd1);
    chk("bempty_valid", 32'(o_rdvalid), 32'd0);
    chk("bempty_data_held", 32'(o_rddata), 32'h37);
    chk("bempty_udf", 32'(o_underflow), 32'(ERR_EN));
    $display("empty wr+rd: count=%0d rdvalid=%0b", o_count, o_rdvalid);
    i_rden = 1'b1;
    step();
    i_rden = 1'b0;
    chk("bempty_readback", 32'(o_rddata), 32'h55);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk("clr2_ovf", 32'(o_overflow), 32'd0);
    chk("clr2_udf", 32'(o_underflow), 32'd0);

    // Asynchronous reset mid-stream at count 5
    for (int i = 0; i < 5; i++) begin
      i_wren = 1'b1; i_wrdata = DW'(8'h60 + i);
      step();
    end
    i_wren = 1'b0;
    chk("mid_pre_count", 32'(o_count), 32'd5);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle_reset("midrst");
    $display("mid-stream reset asserted, count=%0d", o_count);
    step();
    rstn = 1'b1;
    i_wren = 1'b1; i_wrdata = 8'h77;
    step();
    i_wren = 1'b0; i_rden = 1'b1;
    step();
    i_rden = 1'b0;
    chk("post_rst_data", 32'(o_rddata), 32'h77);
    chk("post_rst_valid", 32'(o_rdvalid), 32'd1);
    chk("post_rst_count", 32'(o_count), 32'd0);
    $display("post-reset readback 0x%02h", o_rddata);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
